// File: rtl/muldiv_unit_pkg.sv
// Shared constants, operation/state encodings and small helpers for the
// iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    // Magnitude of a two's-complement value; 0x8000_0000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] v,
                                               input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand, control and HI/LO result bundle between execute-stage control
// and the multiply/divide unit.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitude shift-add multiply and
// restoring divide over 32 iterations, sign fixup, architectural HI/LO.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    md_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              is_div_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              dz_reg;
    logic [XLEN-1:0]   a_orig_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic [XLEN-1:0]   acc_reg;
    logic [XLEN-1:0]   shf_reg;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;
    logic              done_reg;

    logic              op_signed;
    logic              op_div;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign op_signed = md_is_signed(bus.op);
    assign op_div    = md_is_div(bus.op);
    assign a_mag     = md_abs(bus.a, op_signed);
    assign b_mag     = md_abs(bus.b, op_signed);

    // Multiply: acc holds the upper product half, shf the multiplier that
    // drains out while low product bits shift in from the top.
    assign mul_sum   = {1'b0, acc_reg} + (shf_reg[0] ? {1'b0, opnd_reg} : '0);

    // Divide: acc is the partial remainder, shf the dividend draining out
    // at the top while quotient bits fill in at the bottom.
    assign rem_shift = {acc_reg, shf_reg[XLEN-1]};
    assign rem_ge    = (rem_shift >= {1'b0, opnd_reg});
    assign rem_diff  = rem_shift[XLEN-1:0] - opnd_reg;

    assign prod_mag  = {acc_reg, shf_reg};
    assign prod_fix  = neg_q_reg ? (~prod_mag + 1'b1) : prod_mag;
    assign quo_fix   = neg_q_reg ? (~shf_reg + 1'b1) : shf_reg;
    assign rem_fix   = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE: if (bus.start) state_next = MD_CALC;
            MD_CALC: if (cnt_reg == CNT_LAST) state_next = MD_FIX;
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= MD_IDLE;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            a_orig_reg <= '0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            shf_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                MD_IDLE: begin
                    if (bus.start) begin
                        cnt_reg    <= '0;
                        is_div_reg <= op_div;
                        neg_q_reg  <= op_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                        neg_r_reg  <= op_signed & op_div & bus.a[XLEN-1];
                        dz_reg     <= (bus.b == '0);
                        a_orig_reg <= bus.a;
                        acc_reg    <= '0;
                        opnd_reg   <= op_div ? b_mag : a_mag;
                        shf_reg    <= op_div ? a_mag : b_mag;
                    end else begin
                        // MTHI/MTLO only land when no operation is launching.
                        if (bus.hi_we) hi_reg <= bus.wdata;
                        if (bus.lo_we) lo_reg <= bus.wdata;
                    end
                end
                MD_CALC: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (is_div_reg) begin
                        acc_reg <= rem_ge ? rem_diff : rem_shift[XLEN-1:0];
                        shf_reg <= {shf_reg[XLEN-2:0], rem_ge};
                    end else begin
                        acc_reg <= mul_sum[XLEN:1];
                        shf_reg <= {mul_sum[0], shf_reg[XLEN-1:1]};
                    end
                end
                MD_FIX: begin
                    done_reg <= 1'b1;
                    if (is_div_reg) begin
                        // Divide by zero reports the untouched dividend in HI.
                        if (dz_reg) begin
                            lo_reg <= '1;
                            hi_reg <= a_orig_reg;
                        end else begin
                            lo_reg <= quo_fix;
                            hi_reg <= rem_fix;
                        end
                    end else begin
                        hi_reg <= prod_fix[2*XLEN-1:XLEN];
                        lo_reg <= prod_fix[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg != MD_IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// corner sequences and randomized operations against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if bus();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q;
        longint r;
        logic [63:0] ua = {32'h0, a};
        logic [63:0] ub = {32'h0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                        return {32'h0, 32'h8000_0000};
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at the sample point just after the start edge.
    task automatic wait_done(input string name, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        int n = 0;
        int early = 0;
        while (bus.busy && n < 40) begin
            if (bus.done) early++;
            n++;
            @(posedge clk); #1;
        end
        chk({name, " busy_cycles"}, 32'(n), 32'd33);
        chk({name, " done_while_busy"}, 32'(early), 32'd0);
        chk({name, " done"}, {31'h0, bus.done}, 32'h1);
        chk({name, " hi"}, bus.hi, exp_hi);
        chk({name, " lo"}, bus.lo, exp_lo);
        $display("txn %s busy=%0d hi=%h lo=%h exp_hi=%h exp_lo=%h",
                 name, n, bus.hi, bus.lo, exp_hi, exp_lo);
        @(posedge clk); #1;
        chk({name, " done_pulse_end"}, {31'h0, bus.done}, 32'h0);
    endtask

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(name, exp_hi, exp_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] m;
        logic [31:0] ra, rb, hi_before;
        logic [1:0]  rop;
        int n;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{2'b01, 32'd5,         32'd6,         32'h0000_0000, 32'd30};
        vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};
        vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", {31'h0, bus.busy}, 32'h0);
        chk("reset done", {31'h0, bus.done}, 32'h0);
        chk("reset hi", bus.hi, 32'h0);
        chk("reset lo", bus.lo, 32'h0);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo);

        // MTHI/MTLO in IDLE, then the same write colliding with start.
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mt_both hi", bus.hi, 32'hA5A5_A5A5);
        chk("mt_both lo", bus.lo, 32'hA5A5_A5A5);
        $display("txn mt_both hi=%h lo=%h", bus.hi, bus.lo);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_5A5A;
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.start = 1'b0;
        chk("start_wins hi", bus.hi, 32'hA5A5_A5A5);
        chk("start_wins lo", bus.lo, 32'hA5A5_A5A5);
        chk("start_wins busy", {31'h0, bus.busy}, 32'h1);
        wait_done("start_wins", 32'h0, 32'd12);

        // start and MTHI while busy are both dropped.
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        hi_before = bus.hi;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == 10) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd99; bus.b = 32'd3;
                bus.hi_we = 1'b1; bus.wdata = 32'h1234;
            end else begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
            @(posedge clk); #1;
            if (n == 10) begin
                chk("busy_ignore hi", bus.hi, hi_before);
                chk("busy_ignore busy", {31'h0, bus.busy}, 32'h1);
            end
        end
        bus.start = 1'b0; bus.hi_we = 1'b0;
        chk("busy_ignore busy_cycles", 32'(n), 32'd33);
        chk("busy_ignore done", {31'h0, bus.done}, 32'h1);
        chk("busy_ignore hi_result", bus.hi, 32'h0);
        chk("busy_ignore lo_result", bus.lo, 32'd30);
        $display("txn busy_ignore busy=%0d hi=%h lo=%h", n, bus.hi, bus.lo);
        @(posedge clk); #1;
        chk("busy_ignore not_restarted", {31'h0, bus.busy}, 32'h0);

        // Reset in the middle of a divide.
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", {31'h0, bus.busy}, 32'h0);
        chk("midrst done", {31'h0, bus.done}, 32'h0);
        chk("midrst hi", bus.hi, 32'h0);
        chk("midrst lo", bus.lo, 32'h0);
        $display("txn midrst busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        n = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) n++;
        end
        chk("midrst quiet", 32'(n), 32'd0);
        run_op("after_rst", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1, 2:    rb = $urandom_range(1, 300);
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
            m = ref_model(rop, ra, rb);
            run_op($sformatf("rnd%0d op=%0d a=%h b=%h", i, rop, ra, rb),
                   rop, ra, rb, m[63:32], m[31:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
